// File: rtl/imem_ctrl_pkg.sv
// Shared types and defaults for the imem SRAM controller.
// Owner tags route read data back to the requester that issued the read.
package imem_ctrl_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 16;

    typedef enum logic {
        OWN_LD = 1'b0,
        OWN_FE = 1'b1
    } owner_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Bit position of each requester inside the packed {fe, ld} request/grant vectors.
    function automatic logic [1:0] owner_onehot(input owner_t o);
        return (o == OWN_LD) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = loader, bit 1 = fetch.
// Grant is purely combinational; the last-winner flop lives in the caller.
module imem_rr_arb2
    import imem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       enable,
    input  owner_t     last_winner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: the requester that did not win last time goes first.
                2'b11:   gnt = ~owner_onehot(last_winner);
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Arbiter/controller for the single-port imem macro: loader and fetch ports
// share it, and a clear sequencer can fill the whole array with CLR_VALUE.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int             AW        = AW_DEF,
    parameter int             DW        = DW_DEF,
    parameter logic [DW-1:0]  CLR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,

    input  logic          fe_req,
    input  logic [AW-1:0] fe_addr,
    output logic          fe_gnt,
    output logic          fe_rvalid,
    output logic [DW-1:0] fe_rdata,

    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,

    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    localparam int             CNT_W    = AW + 1;
    localparam int             DEPTH    = 2 ** AW;
    localparam logic [AW:0]    CNT_LAST = CNT_W'(DEPTH - 1);

    state_t      state;
    owner_t      last_winner;
    logic [1:0]  gnt;
    logic [AW:0] clr_cnt;
    logic        rd_vld_p0;
    owner_t      rd_own_p0;

    imem_rr_arb2 u_arb (
        .req         ({fe_req, ld_req}),
        .enable      (state == ST_IDLE),
        .last_winner (last_winner),
        .gnt         (gnt)
    );

    assign ld_gnt = gnt[0];
    assign fe_gnt = gnt[1];

    // The macro drives Q for exactly the cycle the owner's rvalid is high.
    assign ld_rdata = mem_q;
    assign fe_rdata = mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_winner <= OWN_FE;
            clr_cnt     <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            rd_vld_p0   <= 1'b0;
            rd_own_p0   <= OWN_LD;
            ld_rvalid   <= 1'b0;
            fe_rvalid   <= 1'b0;
            mem_cen     <= 1'b1;
            mem_wen     <= 1'b1;
            mem_a       <= '0;
            mem_d       <= '0;
        end else begin
            // Stage p1: the macro has sampled the read issued last cycle; steer rvalid to its owner.
            ld_rvalid <= rd_vld_p0 && (rd_own_p0 == OWN_LD);
            fe_rvalid <= rd_vld_p0 && (rd_own_p0 == OWN_FE);

            // Stage p0: default is an idle macro cycle; address/data pins keep their values.
            rd_vld_p0 <= 1'b0;
            mem_cen   <= 1'b1;
            mem_wen   <= 1'b1;
            clr_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt[0]) begin
                        mem_cen     <= 1'b0;
                        mem_wen     <= ~ld_we;
                        mem_a       <= ld_addr;
                        if (ld_we) begin
                            mem_d <= ld_wdata;
                        end
                        rd_vld_p0   <= ~ld_we;
                        rd_own_p0   <= OWN_LD;
                        last_winner <= OWN_LD;
                    end else if (gnt[1]) begin
                        mem_cen     <= 1'b0;
                        mem_wen     <= 1'b1;
                        mem_a       <= fe_addr;
                        rd_vld_p0   <= 1'b1;
                        rd_own_p0   <= OWN_FE;
                        last_winner <= OWN_FE;
                    end
                    // An access granted alongside clr_start is still issued above.
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                        clr_cnt  <= '0;
                    end
                end

                ST_CLEAR: begin
                    mem_cen <= 1'b0;
                    mem_wen <= 1'b0;
                    mem_a   <= clr_cnt[AW-1:0];
                    mem_d   <= CLR_VALUE;
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CNT_LAST) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: SRAM macro model, behavioural reference
// model with per-cycle comparison, directed scenarios and randomized traffic.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    localparam int            AW    = 14;
    localparam int            DW    = 16;
    localparam int            DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLRV  = 16'hC1A5;

    logic          clk;
    logic          rst_n;
    logic          ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata, ld_rdata;
    logic          fe_req, fe_gnt, fe_rvalid;
    logic [AW-1:0] fe_addr;
    logic [DW-1:0] fe_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic          mem_cen, mem_wen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_q;

    imem_ctrl #(.AW(AW), .DW(DW), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt),
        .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port macro
    logic [DW-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram[mem_a] <= mem_d;
            else          mem_q       <= sram[mem_a];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; bit fe; logic [DW-1:0] data; } rd_t;
    rd_t           rq[$];
    rd_t           r;
    logic [DW-1:0] ref_mem [DEPTH];
    int            e = 0;
    bit            started = 0;
    bit            m_clear, m_last_fe, m_ld_rv, m_fe_rv, m_done, m_cen, m_wen;
    int            m_clr_base, idx;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d, m_rdata;
    logic [1:0]    g, cg;

    // Expected {fe_gnt, ld_gnt} from current requests and arbitration history
    function automatic logic [1:0] exp_gnt();
        if (m_clear) return 2'b00;
        if (ld_req && fe_req) return m_last_fe ? 2'b01 : 2'b10;
        return {fe_req, ld_req};
    endfunction

    always @(posedge clk) begin
        e++;
        if (!rst_n) begin
            started = 1; m_clear = 0; m_last_fe = 1; rq.delete();
            m_ld_rv = 0; m_fe_rv = 0; m_done = 0;
            m_cen = 1; m_wen = 1; m_a = '0; m_d = '0;
        end else if (started) begin
            g = exp_gnt();
            m_ld_rv = 0; m_fe_rv = 0; m_done = 0; m_cen = 1; m_wen = 1;
            if (rq.size() > 0 && rq[0].due == e) begin
                r = rq.pop_front();
                m_ld_rv = !r.fe; m_fe_rv = r.fe; m_rdata = r.data;
            end
            if (m_clear) begin
                idx = e - m_clr_base - 1;
                m_cen = 0; m_wen = 0; m_a = AW'(idx); m_d = CLRV;
                ref_mem[idx] = CLRV;
                if (idx == DEPTH - 1) begin m_clear = 0; m_done = 1; end
            end else begin
                if (g[0]) begin
                    m_last_fe = 0; m_cen = 0; m_a = ld_addr;
                    if (ld_we) begin m_wen = 0; m_d = ld_wdata; ref_mem[ld_addr] = ld_wdata; end
                    else rq.push_back('{e + 1, 1'b0, ref_mem[ld_addr]});
                end else if (g[1]) begin
                    m_last_fe = 1; m_cen = 0; m_a = fe_addr;
                    rq.push_back('{e + 1, 1'b1, ref_mem[fe_addr]});
                end
                if (clr_start) begin m_clear = 1; m_clr_base = e; end
            end
        end
    end

    int fe_rv_cnt = 0;
    int done_cnt  = 0;

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (started) begin
            cg = exp_gnt();
            chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, cg[0]});
            chk("fe_gnt", {31'd0, fe_gnt}, {31'd0, cg[1]});
            chk("ld_rvalid", {31'd0, ld_rvalid}, {31'd0, m_ld_rv});
            chk("fe_rvalid", {31'd0, fe_rvalid}, {31'd0, m_fe_rv});
            if (m_ld_rv) chk("ld_rdata", {16'd0, ld_rdata}, {16'd0, m_rdata});
            if (m_fe_rv) chk("fe_rdata", {16'd0, fe_rdata}, {16'd0, m_rdata});
            chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_clear});
            chk("clr_done", {31'd0, clr_done}, {31'd0, m_done});
            chk("mem_cen", {31'd0, mem_cen}, {31'd0, m_cen});
            chk("mem_wen", {31'd0, mem_wen}, {31'd0, m_wen});
            chk("mem_a", {18'd0, mem_a}, {18'd0, m_a});
            if (!m_cen && !m_wen) chk("mem_d", {16'd0, mem_d}, {16'd0, m_d});
            if (fe_rvalid) fe_rv_cnt++;
            if (clr_done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic ld_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        bit gg;
        ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = d; waits = 0;
        do begin @(negedge clk); gg = ld_gnt; tick(); waits++; end while (!gg && waits < 20000);
        if (!gg) chk("ld_gnt timeout", 0, 1);
        ld_req = 0;
    endtask

    task automatic fe_op(input logic [AW-1:0] a, output int waits);
        bit gg;
        fe_req = 1; fe_addr = a; waits = 0;
        do begin @(negedge clk); gg = fe_gnt; tick(); waits++; end while (!gg && waits < 20000);
        if (!gg) chk("fe_gnt timeout", 0, 1);
        fe_req = 0;
    endtask

    task automatic ld_read_expect(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int w;
        ld_op(0, a, '0, w);
        tick();
        chk({nm, " rvalid"}, {31'd0, ld_rvalid}, 1);
        chk(nm, {16'd0, ld_rdata}, {16'd0, exp});
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, d0, f0;
        bit ldg, feg;
        bit gl [6], gf [6], rl [6], rf [6];
        logic [DW-1:0] dq [6];

        rst_n = 0; ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        fe_req = 0; fe_addr = '0; clr_start = 0;
        repeat (3) tick();
        chk("reset mem_cen", {31'd0, mem_cen}, 1);
        chk("reset mem_wen", {31'd0, mem_wen}, 1);
        chk("reset mem_a", {18'd0, mem_a}, 0);
        chk("reset mem_d", {16'd0, mem_d}, 0);
        chk("reset clr_busy", {31'd0, clr_busy}, 0);
        rst_n = 1;
        tick();

        // Loader write 350 @1, then fetch read @1
        ld_op(1, 14'd1, 16'd350, w);
        chk("ld_gnt same cycle", w, 1);
        chk("wr mem_cen", {31'd0, mem_cen}, 0);
        chk("wr mem_wen", {31'd0, mem_wen}, 0);
        chk("wr mem_a", {18'd0, mem_a}, 1);
        chk("wr mem_d", {16'd0, mem_d}, 350);
        fe_op(14'd1, w);
        tick();
        chk("fe read rvalid", {31'd0, fe_rvalid}, 1);
        chk("fe read data", {16'd0, fe_rdata}, 350);

        // Fill 0..63 with their address, stream them back through fetch
        for (int i = 0; i < 64; i++) ld_op(1, AW'(i), DW'(i), w);
        f0 = fe_rv_cnt;
        for (int i = 0; i < 64; i++) fe_op(AW'(i), w);
        repeat (3) tick();
        chk("fe stream rvalid count", fe_rv_cnt - f0, 64);

        // Contention straight after reset: LD, FE, LD, FE
        rst_n = 0; tick(); rst_n = 1;
        ld_req = 1; ld_we = 0; ld_addr = 14'd5; fe_req = 1; fe_addr = 14'd6;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin ld_req = 0; fe_req = 0; end
            @(negedge clk);
            gl[k] = ld_gnt; gf[k] = fe_gnt; rl[k] = ld_rvalid; rf[k] = fe_rvalid;
            dq[k] = rl[k] ? ld_rdata : fe_rdata;
            tick();
        end
        chk("alt gnt ld", {28'd0, gl[0], gl[1], gl[2], gl[3]}, 32'b1010);
        chk("alt gnt fe", {28'd0, gf[0], gf[1], gf[2], gf[3]}, 32'b0101);
        chk("alt rvalid ld", {28'd0, rl[2], rl[3], rl[4], rl[5]}, 32'b1010);
        chk("alt rvalid fe", {28'd0, rf[2], rf[3], rf[4], rf[5]}, 32'b0101);
        chk("alt data k2", {16'd0, dq[2]}, 5);
        chk("alt data k3", {16'd0, dq[3]}, 6);

        // Randomized traffic on a small address window; requests held until granted
        ldg = 1; feg = 1;
        for (int c = 0; c < 1500; c++) begin
            if (!ld_req || ldg) begin
                ld_req = ($urandom_range(0, 2) != 0); ld_we = 1'($urandom_range(0, 1));
                ld_addr = AW'($urandom_range(0, 15)); ld_wdata = DW'($urandom);
            end
            if (!fe_req || feg) begin
                fe_req = ($urandom_range(0, 2) != 0); fe_addr = AW'($urandom_range(0, 15));
            end
            @(negedge clk); ldg = ld_gnt; feg = fe_gnt;
            tick();
        end
        ld_req = 0; fe_req = 0;
        tick();

        // Clear with nonzero contents; read granted the cycle before clr_start
        ld_op(1, 14'd8191, 16'hBEEF, w);
        ld_op(1, 14'd16383, 16'h1234, w);
        d0 = done_cnt;
        fe_op(14'd20, w);
        clr_start = 1;
        tick();
        clr_start = 0;
        @(negedge clk);
        chk("pre-clear read rvalid", {31'd0, fe_rvalid}, 1);
        chk("pre-clear read data", {16'd0, fe_rdata}, 20);
        chk("clr_busy entry", {31'd0, clr_busy}, 1);
        n = 1;
        ld_req = 1; ld_we = 0; ld_addr = 14'd8191; fe_req = 1; fe_addr = 14'd0;
        while (n < 20000) begin
            tick();
            if (n == 500) clr_start = 1;
            if (n == 501) clr_start = 0;
            if (n == 16000) begin ld_req = 0; fe_req = 0; end
            @(negedge clk);
            if (!clr_busy) break;
            n++;
        end
        chk("clr_busy cycles", n, 16384);
        tick(); tick();
        chk("clr_done pulses", done_cnt - d0, 1);
        ld_read_expect("clear addr 0", 14'd0, CLRV);
        ld_read_expect("clear addr 8191", 14'd8191, CLRV);
        ld_read_expect("clear addr 16383", 14'd16383, CLRV);

        // Reset 100 cycles into a clear
        d0 = done_cnt;
        clr_start = 1; tick(); clr_start = 0;
        repeat (100) tick();
        rst_n = 0; tick();
        chk("rst mid-clear mem_cen", {31'd0, mem_cen}, 1);
        chk("rst mid-clear mem_wen", {31'd0, mem_wen}, 1);
        chk("rst mid-clear mem_a", {18'd0, mem_a}, 0);
        chk("rst mid-clear mem_d", {16'd0, mem_d}, 0);
        chk("rst mid-clear busy", {31'd0, clr_busy}, 0);
        chk("rst mid-clear rvalid", {30'd0, ld_rvalid, fe_rvalid}, 0);
        rst_n = 1;
        repeat (50) tick();
        chk("no clr_done after abort", done_cnt - d0, 0);
        ld_op(1, 14'd77, 16'h5A3C, w);
        ld_read_expect("post-reset round trip", 14'd77, 16'h5A3C);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Controller and arbiter in front of the single-port imem SRAM macro (16K x 16; CLK, active-low CEN and WEN, A, D, Q).
- Shares the macro between two requesters:
  - loader port: host/coefficient load, read and write.
  - fetch port: FIR core, read-only.
- Contains a clear sequencer that fills the whole memory with a constant.
- Drives all macro pins from flops.

Parameters:
- AW, 14, address width; DEPTH = 2**AW
- DW, 16, data width
- CLR_VALUE, 0, word written by clear sequence

Ports:
- clk  in  1  system clock; also drives macro CLK
- rst_n  in  1  synchronous active-low reset
- ld_req  in  1  loader request
- ld_we  in  1  1=write, 0=read
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DW  loader read data
- fe_req  in  1  fetch read request
- fe_addr  in  AW  fetch address
- fe_gnt  out  1  fetch request accepted this cycle
- fe_rvalid  out  1  fetch read data valid
- fe_rdata  out  DW  fetch read data
- clr_start  in  1  pulse: begin clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion
- mem_cen  out  1  to macro CEN (active low)
- mem_wen  out  1  to macro WEN (0=write)
- mem_a  out  AW  to macro A
- mem_d  out  DW  to macro D
- mem_q  in  DW  from macro Q

Behaviour:
- Reset (rst_n=0 at posedge):
  - mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.
  - ld_rvalid=fe_rvalid=0, clr_busy=0, clr_done=0.
  - state=IDLE, last_winner=FETCH.
  - Reset mid-clear aborts it; no clr_done is produced.
- States: IDLE, CLEAR.
- IDLE:
  - Grants are combinational from req and last_winner.
  - One requester: always granted.
  - Both requesting: the requester that is not last_winner wins.
  - last_winner updates on every grant.
  - At most one gnt per cycle.
- Accepted request (req & gnt at edge N):
  - At edge N: mem_cen=0, mem_a=addr, mem_wen=~we (fetch is always 1), mem_d=wdata for writes.
  - Macro samples at edge N+1.
  - Reads: owner rvalid is set at edge N+1 and holds for exactly one cycle. rdata = mem_q, combinational passthrough, valid only while rvalid=1.
  - Read latency is 2 edges from acceptance.
  - Writes produce no rvalid.
- No accepted request:
  - mem_cen=1, mem_wen=1.
  - mem_a and mem_d hold their last values.
- Back-to-back:
  - One access per cycle sustained.
  - Each granted read gets its own rvalid on consecutive cycles, in grant order.
  - A registered owner tag routes each rvalid to its port.
- Write then read to the same address on consecutive cycles returns the new data; the macro is synchronous, so no bypass is needed.
- clr_start in IDLE:
  - Enter CLEAR at the next edge; clr_busy=1.
  - A request granted in the same cycle as clr_start is still issued; clear begins the following cycle.
- CLEAR:
  - ld_gnt=fe_gnt=0.
  - Counter runs 0..DEPTH-1: mem_cen=0, mem_wen=0, mem_a=cnt, mem_d=CLR_VALUE, one address per cycle.
  - A read issued just before entry still delivers its rvalid.
  - After address DEPTH-1 is issued: return to IDLE, clr_busy=0, clr_done=1 for one cycle.
  - Total duration is exactly DEPTH cycles of clr_busy.
  - clr_start during CLEAR is ignored.
- Counter: AW+1 bits wide; terminal detect at DEPTH-1, no wrap into a second pass.
- Requests are not queued: a requester holds req (and its addr/data) until gnt.

Decomposition:
- Package imem_ctrl_pkg:
  - typedef owner_t {OWN_LD, OWN_FE}
  - typedef state_t {ST_IDLE, ST_CLEAR}
  - localparams AW_DEF=14, DW_DEF=16
- Sub-module imem_rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], enable, last-winner flop.
  - Output: one-hot gnt[1:0].

Test Plan:
- Loader write 350 @ addr 1, then fetch read @ 1:
  - ld_gnt same cycle; mem_cen=0, mem_wen=0, mem_a=1, mem_d=350 after next edge.
  - fe_rvalid=1 with fe_rdata=350 two edges after fe_gnt.
- Simultaneous ld_req (read @5) and fe_req (read @6) for 4 cycles after reset:
  - Grants alternate LD, FE, LD, FE.
  - rvalids alternate with the correct data per port.
- Loader writes addr i = value i for i=0..63, then fetch streams reads 0..63 back-to-back:
  - 64 consecutive fe_rvalid cycles, data equal to address, zero mismatches.
- clr_start after memory is loaded with nonzero data:
  - clr_busy high exactly 16384 cycles; all gnt=0 meanwhile; one clr_done pulse.
  - Reads of addrs 0, 8191, 16383 return CLR_VALUE.
- Read granted the cycle before clr_start: its rvalid and data still delivered during CLEAR.
- rst_n=0 at cycle 100 of clear:
  - All outputs at reset values next edge; no clr_done.
  - After release, a normal loader write/read round-trip works.
